// File: rtl/stack_arbiter.sv
// Round-robin arbiter sharing one LIFO between the solver and playback requesters.
// Optional STACK_ARB_STATS_EN adds saturating grant/error counters.
module stack_arbiter #(
  parameter int DW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          init,
  input  logic          req0,
  input  logic          req1,
  input  logic          op0,
  input  logic          op1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          ack0,
  output logic          ack1,
  output logic          err,
  output logic [DW-1:0] rdata,
  output logic          busy,
  output logic          mem_push,
  output logic          mem_pop,
  output logic          mem_init,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout,
  input  logic          mem_full,
  input  logic          mem_empty
`ifdef STACK_ARB_STATS_EN
  ,
  output logic [7:0]    gcnt0,
  output logic [7:0]    gcnt1,
  output logic [7:0]    errcnt
`endif
);

  typedef enum logic [1:0] {IDLE, ISSUE, ACK, CLR} state_t;

  state_t        state;
  logic          last_gnt;
  logic          gnt_id;
  logic          gnt_op;
  logic [DW-1:0] gnt_data;
  logic          win_id;

  // On a tie the requester not granted last time wins.
  assign win_id = req1 & (~req0 | ~last_gnt);

`ifdef STACK_ARB_STATS_EN
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      last_gnt <= 1'b1;
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      err      <= 1'b0;
      busy     <= 1'b0;
      rdata    <= '0;
      mem_push <= 1'b0;
      mem_pop  <= 1'b0;
      mem_init <= 1'b0;
      mem_din  <= '0;
      gnt_id   <= 1'b0;
      gnt_op   <= 1'b0;
`ifdef STACK_ARB_STATS_EN
      gcnt0    <= 8'd0;
      gcnt1    <= 8'd0;
      errcnt   <= 8'd0;
`endif
    end else begin
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      err      <= 1'b0;
      mem_push <= 1'b0;
      mem_pop  <= 1'b0;
      mem_init <= 1'b0;
      case (state)
        IDLE: begin
          if (init) begin
            state    <= CLR;
            mem_init <= 1'b1;
            busy     <= 1'b1;
          end else if (req0 || req1) begin
            state    <= ISSUE;
            busy     <= 1'b1;
            gnt_id   <= win_id;
            gnt_op   <= win_id ? op1 : op0;
            gnt_data <= win_id ? wdata1 : wdata0;
          end
        end
        ISSUE: begin
          state <= ACK;
          ack0  <= ~gnt_id;
          ack1  <= gnt_id;
          if (!gnt_op && mem_full) begin
            err <= 1'b1;
          end else if (gnt_op && mem_empty) begin
            err <= 1'b1;
          end else if (!gnt_op) begin
            mem_push <= 1'b1;
            mem_din  <= gnt_data;
          end else begin
            mem_pop <= 1'b1;
            rdata   <= mem_dout;
          end
        end
        ACK: begin
          state    <= IDLE;
          busy     <= 1'b0;
          last_gnt <= gnt_id;
`ifdef STACK_ARB_STATS_EN
          if (err)          errcnt <= sat_inc(errcnt);
          else if (gnt_id)  gcnt1  <= sat_inc(gcnt1);
          else              gcnt0  <= sat_inc(gcnt0);
`endif
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
`ifdef STACK_ARB_STATS_EN
          gcnt0  <= 8'd0;
          gcnt1  <= 8'd0;
          errcnt <= 8'd0;
`endif
        end
      endcase
    end
  end

endmodule
